// File: rtl/atm_pkg.sv
// Shared types and codes for the ATM session controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package atm_pkg;

  // Session states; EXEC, EJECT and RETAIN each last exactly one cycle.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LANG   = 3'd1,
    PIN    = 3'd2,
    OP     = 3'd3,
    EXEC   = 3'd4,
    MORE   = 3'd5,
    EJECT  = 3'd6,
    RETAIN = 3'd7
  } state_t;

  // Operation codes as presented on op_code.
  localparam logic [1:0] OP_WITHDRAW = 2'b00;
  localparam logic [1:0] OP_DEPOSIT  = 2'b01;
  localparam logic [1:0] OP_INQUIRY  = 2'b10;
  localparam logic [1:0] OP_EXIT     = 2'b11;

  // Error codes reported on err_code.
  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_WRONG_PIN = 3'd1;
  localparam logic [2:0] ERR_FUNDS     = 3'd2;
  localparam logic [2:0] ERR_LIMIT     = 3'd3;
  localparam logic [2:0] ERR_OVERFLOW  = 3'd4;
  localparam logic [2:0] ERR_TIMEOUT   = 3'd5;
  localparam logic [2:0] ERR_RETAINED  = 3'd6;

  // States in which the controller waits on the customer and the idle timer runs.
  function automatic logic is_waiting(input state_t s);
    return (s == LANG) || (s == PIN) || (s == OP) || (s == MORE);
  endfunction

endpackage

// File: rtl/atm_session_ctrl_if.sv
// Front-end bundle between card/keypad logic, the account store and the session controller.
// Latency: n/a (wiring only).
// Backpressure: none; all requests are single-cycle strobes.
interface atm_session_ctrl_if #(
  parameter int BAL_W = 20
);
  logic             card_in;
  logic [BAL_W-1:0] acct_balance;
  logic             lang_valid;
  logic             lang_sel;
  logic             pin_valid;
  logic             pin_ok;
  logic             op_valid;
  logic [1:0]       op_code;
  logic [BAL_W-1:0] amount;
  logic             more_valid;
  logic             more_sel;

  logic [BAL_W-1:0] balance;
  logic             language;
  logic             busy;
  logic             op_done;
  logic             error;
  logic [2:0]       err_code;
  logic             card_out;
  logic             card_retained;
  logic             wb_valid;

  modport master (
    output card_in, acct_balance, lang_valid, lang_sel, pin_valid, pin_ok,
           op_valid, op_code, amount, more_valid, more_sel,
    input  balance, language, busy, op_done, error, err_code,
           card_out, card_retained, wb_valid
  );

  modport slave (
    input  card_in, acct_balance, lang_valid, lang_sel, pin_valid, pin_ok,
           op_valid, op_code, amount, more_valid, more_sel,
    output balance, language, busy, op_done, error, err_code,
           card_out, card_retained, wb_valid
  );
endinterface

// File: rtl/atm_timeout_timer.sv
// Inactivity timer: flags expiry after TIMEOUT_CYC consecutive running cycles without a clear.
// Latency: expired rises combinationally in the TIMEOUT_CYC-th running cycle.
// Backpressure: none.
module atm_timeout_timer #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic expired
);
  localparam int                CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count;

  // Count idle running cycles; saturate at the last value so expiry holds until cleared.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clear || !run) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = run && (count == LAST);

endmodule

// File: rtl/atm_session_ctrl.sv
// One-card ATM session controller: insert, language, PIN, operations, eject/retain, writeback.
// Latency: every output is registered; pulses appear in the cycle after the causing edge.
// Backpressure: none; strobes are consumed only in their own state, else dropped.
module atm_session_ctrl #(
  parameter int               BAL_W         = 20,
  parameter int               MAX_TRIES     = 3,
  parameter int               TIMEOUT_CYC   = 1000,
  parameter logic [BAL_W-1:0] SESSION_LIMIT = 20'd5000
) (
  input logic               clk,
  input logic               rst,
  atm_session_ctrl_if.slave bus
);
  import atm_pkg::*;

  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  state_t           state, state_nxt;
  logic [BAL_W-1:0] bal_q, bal_nxt;
  logic [BAL_W-1:0] wd_q, wd_nxt;
  logic [BAL_W-1:0] amt_q, amt_nxt;
  logic [1:0]       opc_q, opc_nxt;
  logic [TRY_W-1:0] tries_q, tries_nxt;
  logic             pin_acc_q, pin_acc_nxt;
  logic             lang_q, lang_nxt;
  logic             busy_q, busy_nxt;
  logic             op_done_q, op_done_nxt;
  logic             error_q, error_nxt;
  logic [2:0]       err_q, err_nxt;
  logic             card_out_q, card_out_nxt;
  logic             retained_q, retained_nxt;
  logic             wb_q, wb_nxt;

  logic             accepted;
  logic             tmr_clear;
  logic             tmr_expired;
  logic [BAL_W:0]   wd_sum;
  logic [BAL_W:0]   dep_sum;

  // One extra bit so the limit compare and the overflow carry cannot wrap.
  assign wd_sum  = {1'b0, wd_q}  + {1'b0, amt_q};
  assign dep_sum = {1'b0, bal_q} + {1'b0, amt_q};

  atm_timeout_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .run     (is_waiting(state)),
    .clear   (tmr_clear),
    .expired (tmr_expired)
  );

  // State register and all registered outputs; reset drops straight to IDLE with no eject.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      bal_q      <= '0;
      wd_q       <= '0;
      amt_q      <= '0;
      opc_q      <= OP_WITHDRAW;
      tries_q    <= '0;
      pin_acc_q  <= 1'b0;
      lang_q     <= 1'b0;
      busy_q     <= 1'b0;
      op_done_q  <= 1'b0;
      error_q    <= 1'b0;
      err_q      <= ERR_NONE;
      card_out_q <= 1'b0;
      retained_q <= 1'b0;
      wb_q       <= 1'b0;
    end else begin
      state      <= state_nxt;
      bal_q      <= bal_nxt;
      wd_q       <= wd_nxt;
      amt_q      <= amt_nxt;
      opc_q      <= opc_nxt;
      tries_q    <= tries_nxt;
      pin_acc_q  <= pin_acc_nxt;
      lang_q     <= lang_nxt;
      busy_q     <= busy_nxt;
      op_done_q  <= op_done_nxt;
      error_q    <= error_nxt;
      err_q      <= err_nxt;
      card_out_q <= card_out_nxt;
      retained_q <= retained_nxt;
      wb_q       <= wb_nxt;
    end
  end

  // Next state, session bookkeeping and next values of every output.
  always_comb begin
    state_nxt    = state;
    bal_nxt      = bal_q;
    wd_nxt       = wd_q;
    amt_nxt      = amt_q;
    opc_nxt      = opc_q;
    tries_nxt    = tries_q;
    pin_acc_nxt  = pin_acc_q;
    lang_nxt     = lang_q;
    err_nxt      = err_q;
    op_done_nxt  = 1'b0;
    error_nxt    = 1'b0;
    card_out_nxt = 1'b0;
    retained_nxt = 1'b0;
    wb_nxt       = 1'b0;
    accepted     = 1'b0;
    tmr_clear    = 1'b0;

    case (state)
      IDLE: begin
        if (bus.card_in) begin
          state_nxt   = LANG;
          bal_nxt     = bus.acct_balance;
          wd_nxt      = '0;
          tries_nxt   = '0;
          pin_acc_nxt = 1'b0;
          err_nxt     = ERR_NONE;
        end
      end

      LANG: begin
        if (bus.lang_valid) begin
          accepted  = 1'b1;
          lang_nxt  = bus.lang_sel;
          state_nxt = PIN;
        end
      end

      PIN: begin
        if (bus.pin_valid) begin
          accepted = 1'b1;
          if (bus.pin_ok) begin
            pin_acc_nxt = 1'b1;
            state_nxt   = OP;
          end else begin
            tries_nxt = tries_q + TRY_W'(1);
            error_nxt = 1'b1;
            err_nxt   = ERR_WRONG_PIN;
            // The attempt that uses up the last try goes straight to retention.
            if (tries_q == TRY_W'(MAX_TRIES - 1)) begin
              state_nxt = RETAIN;
            end
          end
        end
      end

      OP: begin
        if (bus.op_valid) begin
          accepted  = 1'b1;
          opc_nxt   = bus.op_code;
          amt_nxt   = bus.amount;
          state_nxt = (bus.op_code == OP_EXIT) ? EJECT : EXEC;
        end
      end

      EXEC: begin
        state_nxt = MORE;
        case (opc_q)
          OP_WITHDRAW: begin
            if (amt_q > bal_q) begin
              error_nxt = 1'b1;
              err_nxt   = ERR_FUNDS;
            end else if (wd_sum > {1'b0, SESSION_LIMIT}) begin
              error_nxt = 1'b1;
              err_nxt   = ERR_LIMIT;
            end else begin
              bal_nxt     = bal_q - amt_q;
              wd_nxt      = wd_sum[BAL_W-1:0];
              op_done_nxt = 1'b1;
            end
          end
          OP_DEPOSIT: begin
            if (dep_sum[BAL_W]) begin
              error_nxt = 1'b1;
              err_nxt   = ERR_OVERFLOW;
            end else begin
              bal_nxt     = dep_sum[BAL_W-1:0];
              op_done_nxt = 1'b1;
            end
          end
          OP_INQUIRY: begin
            op_done_nxt = 1'b1;
          end
          default: begin
            // Exit never reaches EXEC; it is steered to EJECT from OP.
            op_done_nxt = 1'b0;
          end
        endcase
      end

      MORE: begin
        if (bus.more_valid) begin
          accepted  = 1'b1;
          state_nxt = bus.more_sel ? OP : EJECT;
        end
      end

      EJECT:   state_nxt = IDLE;
      RETAIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // A strobe on the expiry cycle wins; otherwise the idle customer is ejected.
    if (tmr_expired && !accepted) begin
      state_nxt = EJECT;
      error_nxt = 1'b1;
      err_nxt   = ERR_TIMEOUT;
    end

    if (state_nxt == EJECT) begin
      card_out_nxt = 1'b1;
      wb_nxt       = pin_acc_q;
    end

    if (state_nxt == RETAIN) begin
      retained_nxt = 1'b1;
      error_nxt    = 1'b1;
      err_nxt      = ERR_RETAINED;
    end

    busy_nxt  = (state_nxt != IDLE);
    tmr_clear = accepted || (state_nxt != state);
  end

  assign bus.balance       = bal_q;
  assign bus.language      = lang_q;
  assign bus.busy          = busy_q;
  assign bus.op_done       = op_done_q;
  assign bus.error         = error_q;
  assign bus.err_code      = err_q;
  assign bus.card_out      = card_out_q;
  assign bus.card_retained = retained_q;
  assign bus.wb_valid      = wb_q;

endmodule

// File: doc/atm_session_ctrl.md
Name: atm_session_ctrl

Overview:
Parametrised second-generation ATM transaction controller with one card session per run: card insert, language select, PIN check, one or more operations, card eject. It replaces the external timer handshake with an internal inactivity timeout. It adds a PIN-retry card-retention policy, a per-session withdrawal cap, deposit overflow detection, and coded error reporting. It sits between the card/keypad front end and the account store, and writes the final balance back on eject.

Parameters:
BAL_W, 20, balance and amount width in bits
MAX_TRIES, 3, wrong-PIN attempts before card is retained (>=1)
TIMEOUT_CYC, 1000, idle cycles in a waiting state before forced eject (>=2)
SESSION_LIMIT, 20'd5000, max total withdrawn per session (BAL_W bits)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
card_in  in  1  card inserted pulse; honoured only in IDLE
acct_balance  in  BAL_W  account balance, sampled on accepted card_in
lang_valid  in  1  language choice strobe
lang_sel  in  1  1=Arabic, 0=English
pin_valid  in  1  PIN check result strobe
pin_ok  in  1  1=PIN correct
op_valid  in  1  operation request strobe
op_code  in  2  00 withdraw, 01 deposit, 10 inquiry, 11 exit
amount  in  BAL_W  operand, sampled with op_valid
more_valid  in  1  another-service answer strobe
more_sel  in  1  1=another service, 0=finish
balance  out  BAL_W  session working balance
language  out  1  latched language
busy  out  1  high in every state except IDLE
op_done  out  1  one-cycle pulse, operation completed
error  out  1  one-cycle pulse, operation or session failed
err_code  out  3  held until next error or session start: 0 none, 1 wrong PIN, 2 insufficient funds, 3 session limit, 4 deposit overflow, 5 timeout, 6 card retained
card_out  out  1  one-cycle eject pulse
card_retained  out  1  one-cycle retain pulse
wb_valid  out  1  one-cycle pulse; balance is valid for account writeback

Behaviour:
- Reset (rst=0 at posedge): state IDLE; all outputs 0; tries, session_wd and timer cleared.
- All outputs are registered. Pulses assert in the cycle after the causing edge.
- States and transitions:
  - IDLE: card_in -> LANG; load balance=acct_balance; clear tries, session_wd and err_code.
  - LANG: lang_valid -> PIN; latch language.
  - PIN: pin_valid&pin_ok -> OP. pin_valid&!pin_ok -> tries+1, error pulse, err_code=1.
    - If tries reaches MAX_TRIES -> RETAIN; otherwise stay in PIN.
  - OP: op_valid -> EXEC; latch op_code and amount. Exception: op_code=11 -> EJECT.
  - EXEC (exactly one cycle): evaluate the latched operation, then -> MORE.
  - MORE: more_valid&more_sel -> OP; more_valid&!more_sel -> EJECT.
  - EJECT (one cycle): card_out=1, then -> IDLE. wb_valid=1 only if the PIN was accepted this session.
  - RETAIN (one cycle): card_retained=1, error=1, err_code=6; no card_out, no wb_valid; then -> IDLE.
- EXEC arithmetic:
  - Withdraw, first failing check wins:
    - amount>balance -> err 2.
    - session_wd+amount>SESSION_LIMIT, compared at BAL_W+1 bits -> err 3.
    - Otherwise balance-=amount, session_wd+=amount, op_done.
  - Deposit: BAL_W+1-bit sum. Carry set -> err 4 and balance unchanged; otherwise balance updated, op_done.
  - Inquiry: op_done, balance unchanged.
  - amount=0 on withdraw or deposit: op_done, no change.
  - Any failed operation still proceeds to MORE; the balance is never partially updated.
- Timeout:
  - Counter runs only in LANG, PIN, OP and MORE.
  - Cleared on state change and on any strobe accepted in the current state.
  - Reaching TIMEOUT_CYC-1 with no accepted strobe -> error pulse, err_code=5, -> EJECT.
  - A strobe in the same cycle as expiry wins; no timeout.
- Strobes not relevant to the current state are ignored and do not clear the timer.
- card_in outside IDLE is ignored.
- Reset mid-session: immediate IDLE. No card_out and no wb_valid are generated.

Decomposition:
- Package atm_pkg holds:
  - state enum: IDLE, LANG, PIN, OP, EXEC, MORE, EJECT, RETAIN;
  - op_code constants;
  - err_code constants.
- Sub-module atm_timeout_timer:
  - parameter TIMEOUT_CYC;
  - inputs clk, rst, run, clear;
  - output expired;
  - counter width $clog2(TIMEOUT_CYC).

Test Plan:
- Happy path: card_in with acct_balance=1000; lang 0; PIN ok; withdraw 300; more=1; inquiry; more=0 -> balance=700, two op_done pulses, card_out and wb_valid with balance 700.
- PIN failures: 3 wrong PINs with MAX_TRIES=3 -> error pulses with err_code=1 twice, then card_retained, err_code=6, no card_out or wb_valid, return to IDLE.
- Limit and funds: balance 10000; withdraw 4000 ok; withdraw 2000 -> err 3, balance 6000; withdraw 7000 -> err 2.
- Overflow: BAL_W=20, balance 1048000; deposit 1000 -> err 4, balance unchanged; deposit 575 -> balance 1048575, op_done.
- Timeout: TIMEOUT_CYC=8, no input in OP -> error with err_code=5 after 8 idle cycles, then card_out and wb_valid. A strobe on the expiry cycle -> no timeout.
- Reset in MORE with balance modified -> next cycle IDLE, all outputs 0, no wb_valid; next card_in reloads acct_balance.
